jump_physics: RTL and testbench
===============================

Name: jump_physics

Overview:
- Per-player vertical motion generator for the stick-figure fighter; successor to the fixed-speed up/down jump controller.
- Produces a signed per-frame Y velocity with launch impulse, gravity acceleration, terminal fall speed, ceiling clamp, ground snap and opponent head/foot collision.
- Sits between keyboard decode and the player position register; the position block adds motion_y to pos_y once per frame.

Parameters:
- W, 10, coordinate/velocity width; motion_y is signed two's complement.
- GROUND_Y, 300, floor Y; larger Y is lower on screen.
- CEIL_Y, 120, highest allowed Y.
- JUMP_V, 12, launch speed in px/frame, applied as -JUMP_V.
- GRAVITY, 1, velocity increment per frame.
- MAX_FALL_V, 12, terminal downward speed.
- HEAD_GAP, 50, vertical distance treated as body contact.

Ports:
- Clk  in  1  system clock
- Reset  in  1  reset
- frame_tick  in  1  one-Clk pulse per video frame; all physics updates happen on it
- jump  in  1  jump key level
- pos_y  in  W  own current Y, unsigned
- opp_y  in  W  opponent Y, unsigned
- near  in  1  players horizontally overlapping
- motion_y  out  W  signed velocity for the next frame
- airborne  out  1  state is RISE or FALL
- landed  out  1  one-frame_tick-period pulse on touchdown

Behaviour:
- Reset: Reset asynchronous, active-high; clock Clk. Reset forces state GROUND, motion_y=0, airborne=0, landed=0, and clears jump_pend and the edge register. Reset mid-jump aborts immediately.
- Jump capture: a rising edge of jump on any Clk sets jump_pend. jump_pend is cleared on every frame_tick, whether consumed or not. A held key does not retrigger.
- Update rule: all registered outputs change only on the Clk where frame_tick=1, with 1-cycle latency, and hold between ticks.
- States (enum): GROUND, RISE, FALL, LAND.
  - GROUND: motion_y=0. If jump_pend and pos_y>=GROUND_Y, then motion_y=-JUMP_V and go to RISE. Otherwise stay.
  - RISE: v=motion_y+GRAVITY.
    - Head bump: if near and opp_y<=pos_y and pos_y-opp_y<=HEAD_GAP, then motion_y=0 and go to FALL.
    - Ceiling: else if pos_y+motion_y<=CEIL_Y, then motion_y=CEIL_Y-pos_y (clamp) and go to FALL.
    - Apex: else if v>=0, then motion_y=0 and go to FALL.
    - Otherwise motion_y=v.
  - FALL: v=min(motion_y+GRAVITY, MAX_FALL_V).
    - Foot landing on opponent: if near and opp_y>=pos_y and opp_y-pos_y<=HEAD_GAP, then motion_y=0 and go to LAND.
    - Ground snap: else if pos_y+v>=GROUND_Y, then motion_y=GROUND_Y-pos_y and go to LAND.
    - Otherwise motion_y=v.
  - LAND: motion_y=0, landed=1 for this tick period, then go to GROUND on the next tick.
- Priority: collision beats ceiling and ground checks. The jump is evaluated only in GROUND; see the optional feature.
- Arithmetic: sums are computed in W+1 signed bits so pos_y+motion_y cannot wrap. pos_y is zero-extended. If pos_y<CEIL_Y on entry to RISE, the clamp yields a positive value; this is legal and pushes the player down.
- Boundaries:
  - pos_y>GROUND_Y while in GROUND: jump is allowed.
  - pos_y<GROUND_Y while in GROUND: jump is ignored and motion_y stays 0.
  - frame_tick coincident with a jump edge: the edge is seen on that tick.
- airborne is decoded from the registered state.

Optional Feature:
- Macro: DOUBLE_JUMP_EN.
- Defined: one air jump per airborne period. A jump_pend in RISE or FALL, with the air-jump flag clear, sets motion_y=-JUMP_V, forces RISE and sets the flag. The flag clears in LAND and on Reset. Collision checks still take priority over the air jump.
- Undefined: jump_pend is ignored outside GROUND, and no flag register exists.

Decomposition:
- Package jump_physics_pkg holds the state enum type and the default constants (GROUND_Y, CEIL_Y, JUMP_V, GRAVITY, MAX_FALL_V, HEAD_GAP).
- Sub-module edge_latch holds the jump rising-edge detector plus the pending latch that is cleared by frame_tick. It is reusable for the attack keys.

Test Plan (defaults):
- Ground jump, opponent far (near=0): tick 1 gives motion_y=-12 and airborne=1. Ticks 2–12 give -11 down to -1. Tick 13 gives 0 and FALL. Fall ramps +1 per tick to 12, with the final tick snapping to exact 300. landed pulses once, then GROUND.
- Held jump key through landing: no second jump until the key is released and pressed again.
- Head bump: pos_y=200, opp_y=160, near=1 during RISE → next tick motion_y=0, state FALL.
- Ceiling: pos_y=125, motion_y=-8 in RISE → motion_y=-5, then FALL.
- Reset asserted mid-FALL with motion_y=7 → same Clk gives motion_y=0, airborne=0, state GROUND.
- DOUBLE_JUMP_EN: a second press at apex gives motion_y=-12. A third press before landing is ignored. Without the macro, the second press is ignored.

Source files
------------

// File: rtl/jump_physics_pkg.sv
// Purpose : shared state type and default physics constants for jump_physics.
// Ports   : none (package).
// Config  : DOUBLE_JUMP_EN (used by jump_physics) adds one air jump per airborne period.
package jump_physics_pkg;

  localparam int DEF_W          = 10;
  localparam int DEF_GROUND_Y   = 300;
  localparam int DEF_CEIL_Y     = 120;
  localparam int DEF_JUMP_V     = 12;
  localparam int DEF_GRAVITY    = 1;
  localparam int DEF_MAX_FALL_V = 12;
  localparam int DEF_HEAD_GAP   = 50;

  typedef enum logic [1:0] {
    S_GROUND = 2'd0,
    S_RISE   = 2'd1,
    S_FALL   = 2'd2,
    S_LAND   = 2'd3
  } jp_state_t;

endpackage

// File: rtl/jump_physics_if.sv
// Purpose : bundles the per-frame physics inputs and velocity/status outputs.
// Ports   : frame_tick, jump, pos_y, opp_y, near (to DUT); motion_y, airborne, landed (from DUT).
// Modports: master = keyboard/position side, slave = jump_physics.
interface jump_physics_if #(
  parameter int W = jump_physics_pkg::DEF_W
);
  logic                frame_tick;
  logic                jump;
  logic [W-1:0]        pos_y;
  logic [W-1:0]        opp_y;
  logic                near;
  logic signed [W-1:0] motion_y;
  logic                airborne;
  logic                landed;

  modport master (
    output frame_tick, jump, pos_y, opp_y, near,
    input  motion_y, airborne, landed
  );

  modport slave (
    input  frame_tick, jump, pos_y, opp_y, near,
    output motion_y, airborne, landed
  );
endinterface

// File: rtl/edge_latch.sv
// Purpose : key rising-edge detector with a pending flag held until the next clr pulse.
// Latency : pend reflects an edge in the same Clk (combinational OR of the live edge).
// Ports   : Clk, Reset (async, active-high), key level in, clr (frame tick) in, pend out.
module edge_latch (
  input  logic Clk,
  input  logic Reset,
  input  logic key,
  input  logic clr,
  output logic pend
);
  logic key_q;
  logic pend_q;
  logic rise;

  assign rise = key & ~key_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      key_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      key_q <= key;
      // clr wins so a press is only ever offered to one tick
      if (clr)       pend_q <= 1'b0;
      else if (rise) pend_q <= 1'b1;
    end
  end

  // An edge arriving on the clr cycle itself must still be seen by that tick.
  assign pend = pend_q | rise;
endmodule

// File: rtl/jump_physics.sv
// Purpose : per-player vertical velocity FSM (launch, gravity, terminal speed, ceiling, ground, collisions).
// Latency : outputs update one Clk after a frame_tick cycle and hold between ticks; no backpressure.
// Ports   : Clk, Reset (async, active-high), bus (jump_physics_if.slave). Macro DOUBLE_JUMP_EN enables one air jump.
module jump_physics
  import jump_physics_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int GROUND_Y   = DEF_GROUND_Y,
  parameter int CEIL_Y     = DEF_CEIL_Y,
  parameter int JUMP_V     = DEF_JUMP_V,
  parameter int GRAVITY    = DEF_GRAVITY,
  parameter int MAX_FALL_V = DEF_MAX_FALL_V,
  parameter int HEAD_GAP   = DEF_HEAD_GAP
) (
  input  logic         Clk,
  input  logic         Reset,
  jump_physics_if.slave bus
);
  localparam int W1 = W + 1;
  localparam logic signed [W:0] K_GROUND = W1'(GROUND_Y);
  localparam logic signed [W:0] K_CEIL   = W1'(CEIL_Y);
  localparam logic signed [W:0] K_JUMP   = W1'(JUMP_V);
  localparam logic signed [W:0] K_GRAV   = W1'(GRAVITY);
  localparam logic signed [W:0] K_MAXF   = W1'(MAX_FALL_V);
  localparam logic signed [W:0] K_GAP    = W1'(HEAD_GAP);

  jp_state_t    state_q, state_n;
  logic [W-1:0] mot_q;
  logic         landed_q, land_n;
  logic         jump_pend;
`ifdef DOUBLE_JUMP_EN
  logic         air_used_q, air_used_n;
`endif

  // All arithmetic in W+1 signed bits; positions are zero-extended.
  logic signed [W:0] pos_s, opp_s, mot_s, mot_n;
  logic signed [W:0] v_rise, v_fall_raw, v_fall, rise_sum, fall_sum;
  logic              head_hit, foot_hit;

  edge_latch u_jump_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .key   (bus.jump),
    .clr   (bus.frame_tick),
    .pend  (jump_pend)
  );

  assign pos_s      = {1'b0, bus.pos_y};
  assign opp_s      = {1'b0, bus.opp_y};
  assign mot_s      = {mot_q[W-1], mot_q};
  assign v_rise     = mot_s + K_GRAV;
  assign v_fall_raw = mot_s + K_GRAV;
  assign v_fall     = (v_fall_raw > K_MAXF) ? K_MAXF : v_fall_raw;
  assign rise_sum   = pos_s + mot_s;
  assign fall_sum   = pos_s + v_fall;
  // Opponent just above us while rising, or just below us while falling.
  assign head_hit   = bus.near && (opp_s <= pos_s) && ((pos_s - opp_s) <= K_GAP);
  assign foot_hit   = bus.near && (opp_s >= pos_s) && ((opp_s - pos_s) <= K_GAP);

  always_comb begin
    state_n = state_q;
    mot_n   = mot_s;
    land_n  = landed_q;
`ifdef DOUBLE_JUMP_EN
    air_used_n = air_used_q;
`endif
    if (bus.frame_tick) begin
      land_n = 1'b0;
      case (state_q)
        S_GROUND: begin
          mot_n = '0;
          if (jump_pend && (pos_s >= K_GROUND)) begin
            mot_n   = -K_JUMP;
            state_n = S_RISE;
          end
        end
        S_RISE: begin
          if (head_hit) begin
            mot_n   = '0;
            state_n = S_FALL;
          end
`ifdef DOUBLE_JUMP_EN
          else if (jump_pend && !air_used_q) begin
            mot_n      = -K_JUMP;
            air_used_n = 1'b1;
          end
`endif
          else if (rise_sum <= K_CEIL) begin
            // May be positive if we entered RISE above the ceiling.
            mot_n   = K_CEIL - pos_s;
            state_n = S_FALL;
          end else if (!v_rise[W]) begin
            mot_n   = '0;
            state_n = S_FALL;
          end else begin
            mot_n = v_rise;
          end
        end
        S_FALL: begin
          if (foot_hit) begin
            mot_n   = '0;
            state_n = S_LAND;
            land_n  = 1'b1;
          end
`ifdef DOUBLE_JUMP_EN
          else if (jump_pend && !air_used_q) begin
            mot_n      = -K_JUMP;
            state_n    = S_RISE;
            air_used_n = 1'b1;
          end
`endif
          else if (fall_sum >= K_GROUND) begin
            mot_n   = K_GROUND - pos_s;
            state_n = S_LAND;
            land_n  = 1'b1;
          end else begin
            mot_n = v_fall;
          end
        end
        S_LAND: begin
          mot_n   = '0;
          state_n = S_GROUND;
`ifdef DOUBLE_JUMP_EN
          air_used_n = 1'b0;
`endif
        end
        default: begin
          mot_n   = '0;
          state_n = S_GROUND;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_GROUND;
      mot_q    <= '0;
      landed_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      mot_q    <= mot_n[W-1:0];
      landed_q <= land_n;
    end
  end

`ifdef DOUBLE_JUMP_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) air_used_q <= 1'b0;
    else       air_used_q <= air_used_n;
  end
`endif

  assign bus.motion_y = mot_q;
  assign bus.airborne = (state_q == S_RISE) || (state_q == S_FALL);
  assign bus.landed   = landed_q;
endmodule

// File: tb/tb_jump_physics.sv
// Purpose : self-checking bench for jump_physics: table-driven full jump arcs plus corner sequences.
// Checking: expected tick results are queued when a tick is driven and compared by a monitor one Clk later.
// Config  : build with DOUBLE_JUMP_EN defined to check the air-jump expectations.
module tb_jump_physics;
  import jump_physics_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  jump_physics_if #(.W(DEF_W)) bus ();

  jump_physics #(.W(DEF_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic signed [DEF_W-1:0] m;
    logic                    air;
    logic                    land;
  } exp_t;

  typedef struct {
    logic jump;
    int   m;
    logic air;
    logic land;
  } vec_t;

  exp_t  exp_q[$];
  vec_t  tbl[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "reset";
  logic  tick_seen;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s/%s: got %0d, expected %0d", phase, nm, act, req);
    end
  endtask

  always @(posedge Clk) tick_seen <= bus.frame_tick;

  // Scoreboard: every tick cycle must have a queued expectation.
  always @(negedge Clk) begin
    if (tick_seen === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected tick", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("motion_y", int'(bus.motion_y), int'(e.m));
        chk("airborne", int'(bus.airborne), int'(e.air));
        chk("landed",   int'(bus.landed),   int'(e.land));
      end
    end
  end

  // One frame: jump driven together with the tick, result checked next cycle, then hold checked.
  task automatic tick(input logic jv, input int em, input logic ea, input logic el);
    exp_t e;
    e.m    = DEF_W'(em);
    e.air  = ea;
    e.land = el;
    @(negedge Clk);
    exp_q.push_back(e);
    bus.jump       = jv;
    bus.frame_tick = 1'b1;
    @(negedge Clk);
    bus.frame_tick = 1'b0;
    @(negedge Clk);
    chk("hold motion_y", int'(bus.motion_y), em);
    chk("hold landed",   int'(bus.landed),   int'(el));
  endtask

  // Asynchronous reset: asserted between clock edges and checked before the next edge.
  task automatic do_reset();
    @(negedge Clk);
    bus.jump       = 1'b0;
    bus.near       = 1'b0;
    bus.opp_y      = '0;
    bus.frame_tick = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("rst motion_y", int'(bus.motion_y), 0);
    chk("rst airborne", int'(bus.airborne), 0);
    chk("rst landed",   int'(bus.landed),   0);
    @(negedge Clk);
    Reset     = 1'b0;
    bus.pos_y = DEF_W'(DEF_GROUND_Y);
  endtask

  function automatic void add(input logic j, input int m, input logic a, input logic l);
    vec_t v;
    v.jump = j; v.m = m; v.air = a; v.land = l;
    tbl.push_back(v);
  endfunction

  // Full arc from the floor with nothing nearby; 'held' keeps the key down the whole way.
  function automatic void add_arc(input logic held);
    add(1'b1, -12, 1'b1, 1'b0);
    for (int k = 11; k >= 1; k--) add(held, -k, 1'b1, 1'b0);
    add(held, 0, 1'b1, 1'b0);
    for (int k = 1; k <= 11; k++) add(held, k, 1'b1, 1'b0);
    add(held, 12, 1'b0, 1'b1);
    add(held, 0, 1'b0, 1'b0);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.jump       = 1'b0;
    bus.near       = 1'b0;
    bus.opp_y      = '0;
    bus.pos_y      = DEF_W'(DEF_GROUND_Y);
    repeat (3) @(negedge Clk);
    chk("motion_y", int'(bus.motion_y), 0);
    chk("airborne", int'(bus.airborne), 0);
    chk("landed",   int'(bus.landed),   0);
    Reset = 1'b0;

    // Two arcs: first with the key held through landing, then a fresh press.
    phase = "table";
    add_arc(1'b1);
    add(1'b1, 0, 1'b0, 1'b0);
    add(1'b0, 0, 1'b0, 1'b0);
    add_arc(1'b0);
    foreach (tbl[i]) begin
      bus.jump = tbl[i].jump;
      tick(tbl[i].jump, tbl[i].m, tbl[i].air, tbl[i].land);
      bus.pos_y = DEF_W'(int'(bus.pos_y) + tbl[i].m);
    end

    // Jump edge on the tick cycle itself, head bump, then foot landing on the opponent.
    phase = "head_foot";
    do_reset();
    tick(1'b1, -12, 1'b1, 1'b0);
    bus.pos_y = 10'd200; bus.opp_y = 10'd160; bus.near = 1'b1;
    tick(1'b0, 0, 1'b1, 1'b0);
    bus.near = 1'b0;
    tick(1'b0, 1, 1'b1, 1'b0);
    bus.opp_y = 10'd230; bus.near = 1'b1;
    tick(1'b0, 0, 1'b0, 1'b1);
    bus.near = 1'b0;
    tick(1'b0, 0, 1'b0, 1'b0);

    // Ceiling clamp: -8 at y=125 becomes -5, then falling continues.
    phase = "ceiling";
    do_reset();
    tick(1'b1, -12, 1'b1, 1'b0);
    bus.pos_y = 10'd250;
    for (int k = 11; k >= 8; k--) tick(1'b0, -k, 1'b1, 1'b0);
    bus.pos_y = 10'd125;
    tick(1'b0, -5, 1'b1, 1'b0);
    bus.pos_y = 10'd120;
    tick(1'b0, -4, 1'b1, 1'b0);
    bus.pos_y = 10'd305;
    tick(1'b0, -5, 1'b0, 1'b1);

    // Reset while falling at +7 aborts to GROUND.
    phase = "reset_mid_fall";
    do_reset();
    tick(1'b1, -12, 1'b1, 1'b0);
    bus.pos_y = 10'd250;
    for (int k = 11; k >= 1; k--) tick(1'b0, -k, 1'b1, 1'b0);
    tick(1'b0, 0, 1'b1, 1'b0);
    bus.pos_y = 10'd200;
    for (int k = 1; k <= 7; k++) tick(1'b0, k, 1'b1, 1'b0);
    do_reset();
    tick(1'b0, 0, 1'b0, 1'b0);

    // Floor boundary: above floor ignores the press (and it is not kept), below floor allows it.
    phase = "floor_bounds";
    bus.pos_y = 10'd250;
    bus.jump  = 1'b1;
    tick(1'b1, 0, 1'b0, 1'b0);
    bus.pos_y = 10'd300;
    tick(1'b0, 0, 1'b0, 1'b0);
    bus.pos_y = 10'd310;
    tick(1'b1, -12, 1'b1, 1'b0);

    // Presses while airborne: air jump only when the option is built in.
    phase = "air_press";
    do_reset();
    tick(1'b1, -12, 1'b1, 1'b0);
    bus.pos_y = 10'd250;
    for (int k = 11; k >= 1; k--) tick(1'b0, -k, 1'b1, 1'b0);
    tick(1'b0, 0, 1'b1, 1'b0);
`ifdef DOUBLE_JUMP_EN
    tick(1'b1, -12, 1'b1, 1'b0);
    tick(1'b0, -11, 1'b1, 1'b0);
    tick(1'b1, -10, 1'b1, 1'b0);
`else
    tick(1'b1, 1, 1'b1, 1'b0);
    tick(1'b0, 2, 1'b1, 1'b0);
    tick(1'b1, 3, 1'b1, 1'b0);
`endif
    do_reset();

    phase = "end";
    @(negedge Clk);
    chk("leftover expectations", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
